// File: rtl/spi_reg_arbiter_if.sv
// spi_reg_arbiter_if
//   Bus bundle between the SPI slave / local host and spi_reg_arbiter.
//   SPI side : spi_read, spi_write (one-cycle pulses), spi_addr, spi_data
//              in; data_word_send out (held read data).
//   Host side: host_req (held until granted), host_we, host_addr,
//              host_wdata in; host_gnt, host_rvalid (pulses), host_rdata out.
//   Modports : master = requesting side, slave = the arbiter.
interface spi_reg_arbiter_if #(
   parameter int SPI_ADDR_LEN = 8,
   parameter int SPI_WORD_LEN = 16
);
   logic                    spi_read;
   logic                    spi_write;
   logic [SPI_ADDR_LEN-1:0] spi_addr;
   logic [SPI_WORD_LEN-1:0] spi_data;
   logic [SPI_WORD_LEN-1:0] data_word_send;
   logic                    host_req;
   logic                    host_we;
   logic [SPI_ADDR_LEN-1:0] host_addr;
   logic [SPI_WORD_LEN-1:0] host_wdata;
   logic                    host_gnt;
   logic                    host_rvalid;
   logic [SPI_WORD_LEN-1:0] host_rdata;

   modport master (
      output spi_read, spi_write, spi_addr, spi_data,
      output host_req, host_we, host_addr, host_wdata,
      input  data_word_send, host_gnt, host_rvalid, host_rdata
   );

   modport slave (
      input  spi_read, spi_write, spi_addr, spi_data,
      input  host_req, host_we, host_addr, host_wdata,
      output data_word_send, host_gnt, host_rvalid, host_rdata
   );
endinterface

// File: rtl/spi_reg_arbiter.sv
// spi_reg_arbiter
//   Register bank of NUM_REGS x SPI_WORD_LEN words shared between an SPI
//   slave and a local host. SPI requests are parked in a one-deep pending
//   slot and always win arbitration; each access takes one FSM cycle.
//   Ports: master_clock (rising edge), i_rst_n (synchronous, active-low),
//          bus (spi_reg_arbiter_if.slave: SPI and host request/response),
//          err_clr (clears sticky flags), spi_ovf (sticky SPI overrun),
//          addr_err (sticky out-of-range access).
module spi_reg_arbiter #(
   parameter int SPI_ADDR_LEN = 8,
   parameter int SPI_WORD_LEN = 16,
   parameter int NUM_REGS     = 16
) (
   input  logic             master_clock,
   input  logic             i_rst_n,
   spi_reg_arbiter_if.slave bus,
   input  logic             err_clr,
   output logic             spi_ovf,
   output logic             addr_err
);
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [SPI_ADDR_LEN:0] REG_LIMIT = (SPI_ADDR_LEN + 1)'(NUM_REGS);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SPI_ACC  = 2'd1,
      HOST_ACC = 2'd2
   } state_t;

   state_t                  state_r;
   state_t                  state_next_s;
   logic [SPI_WORD_LEN-1:0] bank_r [NUM_REGS];

   logic                    spi_pend_r;
   logic                    pend_we_r;
   logic [SPI_ADDR_LEN-1:0] pend_addr_r;
   logic [SPI_WORD_LEN-1:0] pend_data_r;

   logic [SPI_WORD_LEN-1:0] data_word_send_r;
   logic [SPI_WORD_LEN-1:0] host_rdata_r;
   logic                    host_gnt_r;
   logic                    host_rvalid_r;
   logic                    spi_ovf_r;
   logic                    addr_err_r;

   logic                    spi_pulse_s;
   logic                    spi_accept_s;
   logic                    spi_ovf_set_s;
   logic                    acc_active_s;
   logic                    acc_we_s;
   logic [SPI_ADDR_LEN-1:0] acc_addr_s;
   logic [SPI_WORD_LEN-1:0] acc_wdata_s;
   logic                    acc_in_range_s;
   logic [IDX_W-1:0]        acc_idx_s;
   logic [SPI_WORD_LEN-1:0] acc_rdata_s;

   // The slot frees up at the end of SPI_ACC, so a pulse in that cycle refills it.
   assign spi_pulse_s    = bus.spi_read | bus.spi_write;
   assign spi_accept_s   = spi_pulse_s & (~spi_pend_r | (state_r == SPI_ACC));
   assign spi_ovf_set_s  = spi_pulse_s & spi_pend_r & (state_r != SPI_ACC);
   assign acc_in_range_s = ({1'b0, acc_addr_s} < REG_LIMIT);
   assign acc_idx_s      = acc_addr_s[IDX_W-1:0];

   // Select the source of the current bank access from the FSM state.
   always_comb begin
      acc_active_s = 1'b0;
      acc_we_s     = 1'b0;
      acc_addr_s   = {SPI_ADDR_LEN{1'b0}};
      acc_wdata_s  = {SPI_WORD_LEN{1'b0}};
      case (state_r)
         SPI_ACC: begin
            acc_active_s = 1'b1;
            acc_we_s     = pend_we_r;
            acc_addr_s   = pend_addr_r;
            acc_wdata_s  = pend_data_r;
         end
         HOST_ACC: begin
            acc_active_s = 1'b1;
            acc_we_s     = bus.host_we;
            acc_addr_s   = bus.host_addr;
            acc_wdata_s  = bus.host_wdata;
         end
         default: begin
            acc_active_s = 1'b0;
         end
      endcase
   end

   // Bank read port; out-of-range addresses read as zero.
   always_comb begin
      acc_rdata_s = {SPI_WORD_LEN{1'b0}};
      if (acc_in_range_s) begin
         acc_rdata_s = bank_r[acc_idx_s];
      end else begin
         acc_rdata_s = {SPI_WORD_LEN{1'b0}};
      end
   end

   // Next-state logic. A pulse arriving in IDLE reserves the FSM for SPI so a
   // host request raised in the same cycle cannot slip in ahead of it.
   always_comb begin
      state_next_s = IDLE;
      case (state_r)
         IDLE: begin
            if (spi_pend_r) begin
               state_next_s = SPI_ACC;
            end else if (spi_pulse_s) begin
               state_next_s = IDLE;
            end else if (bus.host_req) begin
               state_next_s = HOST_ACC;
            end else begin
               state_next_s = IDLE;
            end
         end
         SPI_ACC:  state_next_s = IDLE;
         HOST_ACC: state_next_s = IDLE;
         default:  state_next_s = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge master_clock) begin
      if (!i_rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // SPI pending slot; a dropped (overrun) pulse leaves the slot untouched.
   always_ff @(posedge master_clock) begin
      if (!i_rst_n) begin
         spi_pend_r  <= 1'b0;
         pend_we_r   <= 1'b0;
         pend_addr_r <= {SPI_ADDR_LEN{1'b0}};
         pend_data_r <= {SPI_WORD_LEN{1'b0}};
      end else if (spi_accept_s) begin
         spi_pend_r  <= 1'b1;
         pend_we_r   <= bus.spi_write;
         pend_addr_r <= bus.spi_addr;
         pend_data_r <= bus.spi_data;
      end else if (state_r == SPI_ACC) begin
         spi_pend_r  <= 1'b0;
      end
   end

   // Register bank write port.
   always_ff @(posedge master_clock) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            bank_r[i] <= {SPI_WORD_LEN{1'b0}};
         end
      end else if (acc_active_s && acc_we_s && acc_in_range_s) begin
         bank_r[acc_idx_s] <= acc_wdata_s;
      end
   end

   // Registered responses to the SPI slave and the host.
   always_ff @(posedge master_clock) begin
      if (!i_rst_n) begin
         data_word_send_r <= {SPI_WORD_LEN{1'b0}};
         host_rdata_r     <= {SPI_WORD_LEN{1'b0}};
         host_gnt_r       <= 1'b0;
         host_rvalid_r    <= 1'b0;
      end else begin
         host_gnt_r    <= (state_next_s == HOST_ACC);
         host_rvalid_r <= (state_r == HOST_ACC) && !bus.host_we;
         if ((state_r == SPI_ACC) && !pend_we_r) begin
            data_word_send_r <= acc_rdata_s;
         end
         if ((state_r == HOST_ACC) && !bus.host_we) begin
            host_rdata_r <= acc_rdata_s;
         end
      end
   end

   // Sticky error flags; a set event outranks err_clr in the same cycle.
   always_ff @(posedge master_clock) begin
      if (!i_rst_n) begin
         spi_ovf_r  <= 1'b0;
         addr_err_r <= 1'b0;
      end else begin
         if (spi_ovf_set_s) begin
            spi_ovf_r <= 1'b1;
         end else if (err_clr) begin
            spi_ovf_r <= 1'b0;
         end
         if (acc_active_s && !acc_in_range_s) begin
            addr_err_r <= 1'b1;
         end else if (err_clr) begin
            addr_err_r <= 1'b0;
         end
      end
   end

   assign bus.data_word_send = data_word_send_r;
   assign bus.host_rdata     = host_rdata_r;
   assign bus.host_gnt       = host_gnt_r;
   assign bus.host_rvalid    = host_rvalid_r;
   assign spi_ovf            = spi_ovf_r;
   assign addr_err           = addr_err_r;
endmodule

// File: tb/tb_spi_reg_arbiter.sv
// tb_spi_reg_arbiter
//   Directed bench for spi_reg_arbiter: SPI read latency, SPI priority over
//   the host, overrun handling, out-of-range accesses, mid-operation reset.
module tb_spi_reg_arbiter;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int NR = 16;

   logic master_clock = 1'b0;
   logic i_rst_n;
   logic err_clr;
   logic spi_ovf;
   logic addr_err;

   int tests_run    = 0;
   int tests_failed = 0;

   int            w;
   int            n;
   logic          rv;
   logic [DW-1:0] rd;

   spi_reg_arbiter_if #(.SPI_ADDR_LEN(AW), .SPI_WORD_LEN(DW)) bus_if ();

   spi_reg_arbiter #(
      .SPI_ADDR_LEN(AW),
      .SPI_WORD_LEN(DW),
      .NUM_REGS    (NR)
   ) dut (
      .master_clock(master_clock),
      .i_rst_n     (i_rst_n),
      .bus         (bus_if),
      .err_clr     (err_clr),
      .spi_ovf     (spi_ovf),
      .addr_err    (addr_err)
   );

   always #5 master_clock = ~master_clock;

   // Step to just after the next rising edge.
   task automatic tick();
      @(posedge master_clock);
      #1;
   endtask

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One-cycle SPI pulse; returns just after the edge that samples it.
   task automatic spi_pulse(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      bus_if.spi_write = we;
      bus_if.spi_read  = ~we;
      bus_if.spi_addr  = addr;
      bus_if.spi_data  = data;
      tick();
      bus_if.spi_write = 1'b0;
      bus_if.spi_read  = 1'b0;
   endtask

   // One host transaction: returns grant latency and the read response seen
   // in the cycle after the grant.
   task automatic host_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          output int wait_cyc, output logic rvalid, output logic [DW-1:0] rdata);
      bus_if.host_req   = 1'b1;
      bus_if.host_we    = we;
      bus_if.host_addr  = addr;
      bus_if.host_wdata = wdata;
      wait_cyc = 0;
      do begin
         tick();
         wait_cyc++;
      end while (!bus_if.host_gnt && wait_cyc < 20);
      check_value("host_gnt_seen", 32'(bus_if.host_gnt), 32'd1);
      tick();
      rvalid = bus_if.host_rvalid;
      rdata  = bus_if.host_rdata;
      bus_if.host_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      i_rst_n           = 1'b0;
      err_clr           = 1'b0;
      bus_if.spi_read   = 1'b0;
      bus_if.spi_write  = 1'b0;
      bus_if.spi_addr   = 8'd0;
      bus_if.spi_data   = 16'd0;
      bus_if.host_req   = 1'b0;
      bus_if.host_we    = 1'b0;
      bus_if.host_addr  = 8'd0;
      bus_if.host_wdata = 16'd0;
      repeat (3) tick();

      // Reset state
      check_value("rst_dws",      32'(bus_if.data_word_send), 32'h0);
      check_value("rst_hrdata",   32'(bus_if.host_rdata),     32'h0);
      check_value("rst_gnt",      32'(bus_if.host_gnt),       32'h0);
      check_value("rst_rvalid",   32'(bus_if.host_rvalid),    32'h0);
      check_value("rst_ovf",      32'(spi_ovf),               32'h0);
      check_value("rst_addr_err", 32'(addr_err),              32'h0);
      i_rst_n = 1'b1;
      tick();

      // SPI write then read: data appears exactly 3 cycles after the read pulse
      spi_pulse(1'b1, 8'd3, 16'hA5A5);
      repeat (3) tick();
      spi_pulse(1'b0, 8'd3, 16'h0000);
      tick();
      check_value("spi_rd_lat2", 32'(bus_if.data_word_send), 32'h0);
      tick();
      check_value("spi_rd_lat3", 32'(bus_if.data_word_send), 32'hA5A5);

      // Host request and SPI write in the same cycle: SPI first, grant later
      bus_if.host_req   = 1'b1;
      bus_if.host_we    = 1'b0;
      bus_if.host_addr  = 8'd5;
      bus_if.spi_write  = 1'b1;
      bus_if.spi_addr   = 8'd5;
      bus_if.spi_data   = 16'h1234;
      tick();
      bus_if.spi_write  = 1'b0;
      n = 1;
      while (!bus_if.host_gnt && n < 20) begin
         tick();
         n++;
      end
      check_value("prio_gnt_lat", 32'(n), 32'd4);
      tick();
      bus_if.host_req = 1'b0;
      check_value("prio_rvalid", 32'(bus_if.host_rvalid), 32'd1);
      check_value("prio_rdata",  32'(bus_if.host_rdata),  32'h1234);
      check_value("prio_gnt_pulse", 32'(bus_if.host_gnt), 32'd0);
      tick();
      check_value("prio_rvalid_pulse", 32'(bus_if.host_rvalid), 32'd0);

      // Overrun: second pulse while pending is dropped; set beats err_clr
      spi_pulse(1'b1, 8'd7, 16'h1111);
      err_clr = 1'b1;
      spi_pulse(1'b1, 8'd7, 16'h2222);
      err_clr = 1'b0;
      check_value("ovf_set_wins", 32'(spi_ovf), 32'd1);
      repeat (3) tick();
      spi_pulse(1'b0, 8'd7, 16'h0000);
      repeat (2) tick();
      check_value("ovf_first_kept", 32'(bus_if.data_word_send), 32'h1111);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check_value("ovf_clr", 32'(spi_ovf), 32'd0);

      // A pulse landing in SPI_ACC is accepted, not an overrun
      spi_pulse(1'b1, 8'd8, 16'h0808);
      tick();
      spi_pulse(1'b1, 8'd9, 16'h0909);
      check_value("acc_no_ovf", 32'(spi_ovf), 32'd0);
      repeat (3) tick();
      host_op(1'b0, 8'd8, 16'h0000, w, rv, rd);
      check_value("acc_first_wr", 32'(rd), 32'h0808);
      check_value("host_gnt_lat", 32'(w), 32'd1);
      host_op(1'b0, 8'd9, 16'h0000, w, rv, rd);
      check_value("acc_second_wr", 32'(rd), 32'h0909);

      // Simultaneous read and write pulses: write wins
      bus_if.spi_read  = 1'b1;
      bus_if.spi_write = 1'b1;
      bus_if.spi_addr  = 8'd11;
      bus_if.spi_data  = 16'h0B0B;
      tick();
      bus_if.spi_read  = 1'b0;
      bus_if.spi_write = 1'b0;
      repeat (3) tick();
      host_op(1'b0, 8'd11, 16'h0000, w, rv, rd);
      check_value("both_pulse_wr", 32'(rd), 32'h0B0B);

      // Host write then read back-to-back, then SPI view of the same register
      host_op(1'b1, 8'd10, 16'hBEEF, w, rv, rd);
      check_value("hwr_no_rvalid", 32'(rv), 32'd0);
      host_op(1'b0, 8'd10, 16'h0000, w, rv, rd);
      check_value("hrd_rvalid", 32'(rv), 32'd1);
      check_value("hrd_new_val", 32'(rd), 32'hBEEF);
      spi_pulse(1'b0, 8'd10, 16'h0000);
      repeat (2) tick();
      check_value("spi_sees_host_wr", 32'(bus_if.data_word_send), 32'hBEEF);

      // Out-of-range accesses
      host_op(1'b1, 8'd16, 16'hFFFF, w, rv, rd);
      check_value("oor_wr_err", 32'(addr_err), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check_value("addr_err_clr", 32'(addr_err), 32'd0);
      host_op(1'b0, 8'd5, 16'h0000, w, rv, rd);
      check_value("inrange_rd", 32'(rd), 32'h1234);
      host_op(1'b0, 8'd16, 16'h0000, w, rv, rd);
      check_value("oor_rd_rvalid", 32'(rv), 32'd1);
      check_value("oor_rd_zero", 32'(rd), 32'h0);
      check_value("oor_rd_err", 32'(addr_err), 32'd1);
      host_op(1'b0, 8'd0, 16'h0000, w, rv, rd);
      check_value("oor_bank_intact", 32'(rd), 32'h0);
      spi_pulse(1'b0, 8'd200, 16'h0000);
      repeat (2) tick();
      check_value("oor_spi_rd_zero", 32'(bus_if.data_word_send), 32'h0);

      // Reset right after an SPI write pulse discards the pending write
      spi_pulse(1'b0, 8'd10, 16'h0000);
      repeat (2) tick();
      check_value("pre_rst_dws", 32'(bus_if.data_word_send), 32'hBEEF);
      host_op(1'b0, 8'd9, 16'h0000, w, rv, rd);
      spi_pulse(1'b1, 8'd12, 16'h5A5A);
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      check_value("post_rst_dws",      32'(bus_if.data_word_send), 32'h0);
      check_value("post_rst_hrdata",   32'(bus_if.host_rdata),     32'h0);
      check_value("post_rst_gnt",      32'(bus_if.host_gnt),       32'h0);
      check_value("post_rst_rvalid",   32'(bus_if.host_rvalid),    32'h0);
      check_value("post_rst_ovf",      32'(spi_ovf),               32'h0);
      check_value("post_rst_addr_err", 32'(addr_err),              32'h0);
      repeat (3) tick();
      host_op(1'b0, 8'd12, 16'h0000, w, rv, rd);
      check_value("rst_dropped_wr", 32'(rd), 32'h0);
      host_op(1'b0, 8'd3, 16'h0000, w, rv, rd);
      check_value("rst_bank_clear", 32'(rd), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/spi_reg_arbiter.md
SPI_REG_ARBITER -- requirements
Module: spi_reg_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL declare parameter SPI_ADDR_LEN, default 8, the address width.
REQ-002 The block SHALL declare parameter SPI_WORD_LEN, default 16, the register word width.
REQ-003 The block SHALL declare parameter NUM_REGS, default 16, the number of implemented registers (addresses 0..NUM_REGS-1).

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have master_clock, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have i_rst_n, input, 1, reset that is synchronous and active-low.
REQ-006 The block SHALL have spi_read, input, 1, a one-cycle read request pulse from the SPI slave.
REQ-007 The block SHALL have spi_write, input, 1, a one-cycle write request pulse from the SPI slave.
REQ-008 The block SHALL have spi_addr, input, SPI_ADDR_LEN, the SPI access address, sampled with the pulse.
REQ-009 The block SHALL have spi_data, input, SPI_WORD_LEN, the SPI write data, sampled with the pulse.
REQ-010 The block SHALL have data_word_send, output, SPI_WORD_LEN, the read data returned to the SPI slave.
REQ-011 The block SHALL have host_req, input, 1, the local host request, held high until granted.
REQ-012 The block SHALL have host_we, input, 1, host write enable (1 = write, 0 = read), valid with host_req.
REQ-013 The block SHALL have host_addr, input, SPI_ADDR_LEN, and host_wdata, input, SPI_WORD_LEN, valid with host_req.
REQ-014 The block SHALL have host_gnt, output, 1, a one-cycle grant pulse.
REQ-015 The block SHALL have host_rvalid, output, 1, a one-cycle read-data-valid pulse.
REQ-016 The block SHALL have host_rdata, output, SPI_WORD_LEN, the host read data.
REQ-017 The block SHALL have err_clr, input, 1, which clears the sticky flags.
REQ-018 The block SHALL have spi_ovf, output, 1, a sticky SPI overrun flag.
REQ-019 The block SHALL have addr_err, output, 1, a sticky out-of-range access flag.

Function
REQ-020 The block SHALL own a NUM_REGS x SPI_WORD_LEN register bank shared by the SPI and host ports.
REQ-021 On spi_read or spi_write, the block SHALL latch spi_addr, spi_data and the direction into a pending slot and set spi_pend on the next cycle; if both pulses are high together, write SHALL take precedence.
REQ-022 If an SPI pulse arrives while spi_pend=1, the block SHALL drop the new request, keep the pending one, and set spi_ovf.
REQ-023 The FSM SHALL have states IDLE, SPI_ACC and HOST_ACC; each ACC state SHALL last exactly one cycle and then return to IDLE.
REQ-024 In IDLE, the FSM SHALL enter SPI_ACC if spi_pend=1; otherwise it SHALL enter HOST_ACC if host_req=1; otherwise it SHALL stay in IDLE. SPI has fixed priority.
REQ-025 In SPI_ACC, the block SHALL perform the access and clear spi_pend; a new pulse arriving in this same cycle SHALL be accepted and SHALL NOT count as an overrun.
REQ-026 For an SPI read, data_word_send SHALL be updated at the end of SPI_ACC and SHALL hold until the next SPI read. Latency: pulse at cycle N gives data_word_send valid at cycle N+3 (when the FSM is free).
REQ-027 In HOST_ACC, host_gnt SHALL be 1 for that cycle. A write SHALL update the bank that cycle. For a read, host_rdata SHALL be updated and host_rvalid SHALL pulse in the following cycle.
REQ-028 A host request SHALL be issued at most once every 2 cycles. The host SHALL deassert host_req, or present a new transaction, in the cycle after host_gnt.
REQ-029 An address >= NUM_REGS SHALL cause the write to be ignored, the read to return 0, and addr_err to be set; the grant and timing SHALL be unchanged.
REQ-030 err_clr=1 SHALL clear spi_ovf and addr_err. A set event in the same cycle SHALL win.
REQ-031 A read and a write to the same register in consecutive cycles SHALL return the newly written value.

Reset
REQ-032 When i_rst_n=0 at a clock edge, the block SHALL clear all bank registers, data_word_send, host_rdata, host_gnt, host_rvalid, spi_ovf, addr_err and spi_pend, and SHALL set the FSM to IDLE.
REQ-033 A reset asserted mid-operation SHALL discard any pending or in-flight access, so that no write is completed after reset.

Verification
REQ-034 Drive spi_write addr=3 data=0xA5A5, then spi_read addr=3 -> data_word_send=0xA5A5 at 3 cycles after the read pulse.
REQ-035 Hold host_req with a spi_write pulse in the same cycle -> SPI_ACC first, host_gnt one cycle later via IDLE, and the host read of that address returns the SPI data.
REQ-036 Send a second spi_write pulse while spi_pend=1 -> spi_ovf=1 and the first data is written; pulse err_clr -> spi_ovf=0.
REQ-037 Host read of addr=NUM_REGS -> host_rvalid pulse, host_rdata=0, addr_err=1, and the bank is unchanged.
REQ-038 Assert i_rst_n=0 the cycle after an SPI write pulse -> the register remains 0 and all outputs are 0 after reset.
